// File: rtl/sync_pkg.sv
// sync_pkg: shared widths, accumulator width helper and product bundle
// for the STF autocorrelation window accumulator.
package sync_pkg;

  localparam int PROD_W_DEF = 29;
  localparam int WIN_DEF    = 16;

  function automatic int acc_w(input int prod_w, input int win);
    return prod_w + $clog2(win);
  endfunction

  typedef struct packed {
    logic signed [PROD_W_DEF-1:0] re;
    logic signed [PROD_W_DEF-1:0] im;
  } prod_t;

endpackage

// File: rtl/sync_ring_buffer.sv
// sync_ring_buffer: DEPTH x DW circular delay line, write at wp, wp wraps.
// Ports: clk, rst_n, clr (wp->0), we, wdata, rdata (oldest entry, comb).
module sync_ring_buffer #(
  parameter int DW    = 58,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [DW-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so the pointer wraps by overflow.
  always_comb begin
    wp_d = wp_q;
    if (clr)     wp_d = '0;
    else if (we) wp_d = wp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_q <= '0;
    else        wp_q <= wp_d;
  end

  // Contents need no reset: the top masks reads until the window is full.
  always_ff @(posedge clk) begin
    if (we) mem_q[wp_q] <= wdata;
  end

  assign rdata = mem_q[wp_q];

endmodule

// File: rtl/sync_corr_window_acc.sv
// sync_corr_window_acc: running sum of the last WIN products (re/im) with
// valid/ready in/out; out_mag=|re|+|im| only when SYNC_CORR_MAG_EN defined.
module sync_corr_window_acc
  import sync_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int WIN    = WIN_DEF,
  parameter int ACC_W  = acc_w(PROD_W, WIN)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_re,
  input  logic signed [PROD_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_re,
  output logic signed [ACC_W-1:0]  out_im
`ifdef SYNC_CORR_MAG_EN
  ,
  output logic        [ACC_W:0]    out_mag
`endif
);

  localparam int CW = $clog2(WIN + 1);
  localparam int XW = ACC_W - PROD_W;
  localparam logic [CW-1:0] WIN_C  = CW'(WIN);
  localparam logic [CW-1:0] LAST_C = CW'(WIN - 1);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic signed [ACC_W-1:0]  ore_q, ore_d;
  logic signed [ACC_W-1:0]  oim_q, oim_d;
  logic                     vld_q, vld_d;
  logic                     accept, full;
  logic [2*PROD_W-1:0]      old_w;
  logic signed [PROD_W-1:0] old_re, old_im;
  logic signed [ACC_W-1:0]  nre, nim;

  sync_ring_buffer #(
    .DW    (2*PROD_W),
    .DEPTH (WIN)
  ) u_ring (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (clear),
    .we    (accept),
    .wdata ({in_re, in_im}),
    .rdata (old_w)
  );

  assign in_ready = ap_rst_n & ~clear & (~vld_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign full     = (cnt_q == WIN_C);

  // Slots not yet written during fill count as zero.
  assign old_re = full ? old_w[2*PROD_W-1:PROD_W] : '0;
  assign old_im = full ? old_w[PROD_W-1:0]        : '0;

  assign nre = acc_re_q
             + {{XW{in_re[PROD_W-1]}}, in_re}
             - {{XW{old_re[PROD_W-1]}}, old_re};
  assign nim = acc_im_q
             + {{XW{in_im[PROD_W-1]}}, in_im}
             - {{XW{old_im[PROD_W-1]}}, old_im};

`ifdef SYNC_CORR_MAG_EN
  logic [ACC_W:0] mag_q, mag_d;

  function automatic logic [ACC_W-1:0] absv(
    input logic signed [ACC_W-1:0] v
  );
    // Most negative value maps to its unsigned magnitude.
    return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction
`endif

  always_comb begin
    cnt_d    = cnt_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    vld_d    = vld_q;
    ore_d    = ore_q;
    oim_d    = oim_q;
`ifdef SYNC_CORR_MAG_EN
    mag_d    = mag_q;
`endif
    if (clear) begin
      cnt_d    = '0;
      acc_re_d = '0;
      acc_im_d = '0;
      vld_d    = 1'b0;
      ore_d    = '0;
      oim_d    = '0;
`ifdef SYNC_CORR_MAG_EN
      mag_d    = '0;
`endif
    end else begin
      if (accept) begin
        acc_re_d = nre;
        acc_im_d = nim;
        if (!full) cnt_d = cnt_q + 1'b1;
      end
      // The WIN-th accept already completes the window.
      if (accept && cnt_q >= LAST_C) begin
        vld_d = 1'b1;
        ore_d = nre;
        oim_d = nim;
`ifdef SYNC_CORR_MAG_EN
        mag_d = {1'b0, absv(nre)} + {1'b0, absv(nim)};
`endif
      end else if (out_ready) begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q    <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      vld_q    <= 1'b0;
      ore_q    <= '0;
      oim_q    <= '0;
`ifdef SYNC_CORR_MAG_EN
      mag_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      vld_q    <= vld_d;
      ore_q    <= ore_d;
      oim_q    <= oim_d;
`ifdef SYNC_CORR_MAG_EN
      mag_q    <= mag_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign out_re    = ore_q;
  assign out_im    = oim_q;
`ifdef SYNC_CORR_MAG_EN
  assign out_mag   = mag_q;
`endif

endmodule

// File: tb/tb_sync_corr_window_acc.sv
// tb_sync_corr_window_acc: queue-based window model checked every cycle,
// plus directed literal checks for fill, eviction, range, stall, clear, reset.
module tb_sync_corr_window_acc;

  localparam int PW = 29;
  localparam int WN = 16;
  localparam int AW = 33;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [PW-1:0] in_re = '0;
  logic signed [PW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] out_re;
  logic signed [AW-1:0] out_im;
`ifdef SYNC_CORR_MAG_EN
  logic        [AW:0]   out_mag;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_corr_window_acc dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
`ifdef SYNC_CORR_MAG_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: the window is literally the last WN accepted samples.
  longint mq_re[$];
  longint mq_im[$];
  bit     exp_v = 1'b0;
  longint exp_re = 0;
  longint exp_im = 0;

  function automatic longint qsum(input longint q[$]);
    longint s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit model_rdy();
    return rst_n && !clear && (!exp_v || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      mq_re.delete();
      mq_im.delete();
      exp_v  = 1'b0;
      exp_re = 0;
      exp_im = 0;
    end else if (in_valid && model_rdy()) begin
      mq_re.push_back(longint'(in_re));
      mq_im.push_back(longint'(in_im));
      if (mq_re.size() > WN) begin
        void'(mq_re.pop_front());
        void'(mq_im.pop_front());
      end
      if (mq_re.size() == WN) begin
        exp_v  = 1'b1;
        exp_re = qsum(mq_re);
        exp_im = qsum(mq_im);
      end
    end else if (out_ready) begin
      exp_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", longint'(in_ready), longint'(model_rdy()));
    chk("out_valid", longint'(out_valid), longint'(exp_v));
    if (exp_v) begin
      chk("out_re", longint'(out_re), exp_re);
      chk("out_im", longint'(out_im), exp_im);
`ifdef SYNC_CORR_MAG_EN
      chk("out_mag", longint'(out_mag), labs(exp_re) + labs(exp_im));
`endif
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic put(input longint re, input longint im);
    bit a;
    int n = 0;
    in_valid = 1'b1;
    in_re    = PW'(re);
    in_im    = PW'(im);
    forever begin
      @(negedge clk);
      a = model_rdy();
      @(posedge clk);
      #1;
      if (a) break;
      n++;
      if (n > 50) begin
        chk("put_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear(input bit v);
    in_valid = v;
    in_re    = PW'(1000);
    in_im    = PW'(-1000);
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic const_run(input string tag);
    for (int i = 1; i <= 20; i++) begin
      put(1, -1);
      if (i == 15) chk({tag, "_v15"}, longint'(out_valid), 0);
      if (i == 16 || i == 20) begin
        chk({tag, "_v"}, longint'(out_valid), 1);
        chk({tag, "_re"}, longint'(out_re), 16);
        chk({tag, "_im"}, longint'(out_im), -16);
      end
    end
  endtask

  localparam longint P28 = 64'sd1 << 28;

  initial begin
    #1 rst_n = 1'b0;
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_re", longint'(out_re), 0);

    // constant stream
    const_run("t1");
    idle(2);

    // impulse and eviction
    do_clear(1'b0);
    put(P28 - 1, 0);
    for (int i = 2; i <= 17; i++) begin
      put(0, 0);
      if (i == 16) chk("t2_full", longint'(out_re), P28 - 1);
      if (i == 17) chk("t2_evict", longint'(out_re), 0);
    end
    idle(1);

    // most negative full window
    do_clear(1'b0);
    for (int i = 1; i <= 16; i++) begin
      put(-P28, -P28);
      if (i == 8) idle(3);
    end
    chk("t3_re", longint'(out_re), -(64'sd1 << 32));
    chk("t3_im", longint'(out_im), -(64'sd1 << 32));
`ifdef SYNC_CORR_MAG_EN
    chk("t3_mag", longint'(out_mag), 64'sd1 << 33);
`endif

    // downstream stall
    out_ready = 1'b0;
    fork
      put(5, 7);
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("t4_rdy", longint'(in_ready), 0);
          chk("t4_hold", longint'(out_re), -(64'sd1 << 32));
        end
        out_ready = 1'b1;
      end
    join
    chk("t4_re", longint'(out_re), -15 * P28 + 5);
    chk("t4_im", longint'(out_im), -15 * P28 + 7);
    put(3, 4);
    idle(2);
    put(-2, 6);

    // clear mid-stream with a sample offered
    in_valid = 1'b1;
    do_clear(1'b1);
    chk("t5_v", longint'(out_valid), 0);
    chk("t5_re", longint'(out_re), 0);
    for (int i = 1; i <= 16; i++) begin
      put(i, 2 * i);
      if (i == 15) chk("t5_v15", longint'(out_valid), 0);
    end
    chk("t5_re16", longint'(out_re), 136);
    chk("t5_im16", longint'(out_im), 272);

    // async reset during RUN
    put(9, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_v", longint'(out_valid), 0);
    chk("t6_re", longint'(out_re), 0);
    chk("t6_im", longint'(out_im), 0);
    chk("t6_rdy", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    const_run("t6");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
